// File: rtl/stream_compare_pkg.sv
// rtl/stream_compare_pkg.sv - shared state and status types for the compare run controller
package stream_compare_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } cr_state_e;

  typedef struct packed {
    logic done;
    logic pass;
    logic timed_out;
    logic aborted;
  } cr_status_t;

  localparam logic [31:0] CYC_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/compare_run_ctrl.sv
// rtl/compare_run_ctrl.sv - sequences clear, gated run, drain and latch of a stream comparator
module compare_run_ctrl
  import stream_compare_pkg::*;
#(
  parameter int CLEAR_CYCLES = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        totalReset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_window,
  input  logic [31:0] cfg_err_limit,
  input  logic [31:0] cfg_timeout,
  input  logic        beat,
  input  logic [31:0] cmp_err_count,
  output logic        cmp_reset,
  output logic        cmp_latch,
  output logic        gate_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic        aborted,
  output logic [2:0]  state,
  output logic [31:0] run_cycles
);

  // Counters are loaded with N-1 so the phase lasts exactly N cycles.
  localparam logic [31:0] CLEAR_LOAD = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

  cr_state_e   state_q;
  cr_status_t  status_q;
  logic [31:0] beat_cnt;
  logic [31:0] phase_cnt;
  logic [31:0] beat_cnt_nxt;
  logic        win_hit;
  logic        err_hit;
  logic        tmo_hit;

  // Window exit looks at the post-increment count so RUN ends on the cycle
  // that delivers the last beat; the timeout compare is widened so a
  // saturated run_cycles can never wrap into a false match.
  assign gate_en      = (state_q == ST_RUN) && (beat_cnt < cfg_window);
  assign beat_cnt_nxt = beat_cnt + {31'd0, gate_en && beat};
  assign win_hit      = (beat_cnt_nxt == cfg_window);
  assign err_hit      = (cmp_err_count > cfg_err_limit);
  assign tmo_hit      = (cfg_timeout != 32'd0) &&
                        (({1'b0, run_cycles} + 33'd1) == {1'b0, cfg_timeout});

  assign state     = state_q;
  assign done      = status_q.done;
  assign pass      = status_q.pass;
  assign timed_out = status_q.timed_out;
  assign aborted   = status_q.aborted;

  // Run sequencer: abort overrides everything, otherwise walk the phases.
  always_ff @(posedge clk or negedge totalReset) begin
    if (!totalReset) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      beat_cnt   <= '0;
      phase_cnt  <= '0;
      run_cycles <= '0;
      cmp_reset  <= 1'b0;
      cmp_latch  <= 1'b0;
      busy       <= 1'b0;
    end else if (abort && (state_q != ST_IDLE)) begin
      state_q          <= ST_IDLE;
      cmp_reset        <= 1'b0;
      cmp_latch        <= 1'b0;
      busy             <= 1'b0;
      status_q.aborted <= 1'b1;
      status_q.done    <= 1'b0;
      status_q.pass    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_CLEAR;
            phase_cnt  <= CLEAR_LOAD;
            cmp_reset  <= 1'b1;
            busy       <= 1'b1;
            status_q   <= '0;
            run_cycles <= '0;
            beat_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (phase_cnt == 32'd0) begin
            state_q   <= ST_RUN;
            cmp_reset <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 32'd1;
          end
        end
        ST_RUN: begin
          beat_cnt <= beat_cnt_nxt;
          if (run_cycles != CYC_SAT) begin
            run_cycles <= run_cycles + 32'd1;
          end
          if (win_hit || err_hit || tmo_hit) begin
            state_q            <= ST_DRAIN;
            phase_cnt          <= DRAIN_LOAD;
            status_q.timed_out <= tmo_hit;
          end
        end
        ST_DRAIN: begin
          if (phase_cnt == 32'd0) begin
            state_q   <= ST_LATCH;
            cmp_latch <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 32'd1;
          end
        end
        ST_LATCH: begin
          cmp_latch     <= 1'b0;
          busy          <= 1'b0;
          status_q.pass <= (cmp_err_count <= cfg_err_limit) && !status_q.timed_out;
          status_q.done <= 1'b1;
          state_q       <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/compare_run_ctrl.md
COMPARE_RUN_CTRL -- requirements
Module: compare_run_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 2: cycles the comparator reset is held.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2: cycles waited after gating stops, before latch.
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port totalReset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle run request.
REQ-006 SHALL have port abort, input, 1: one-cycle abort request.
REQ-007 SHALL have port cfg_window, input, 32: beats per run.
REQ-008 SHALL have port cfg_err_limit, input, 32: maximum errors for pass.
REQ-009 SHALL have port cfg_timeout, input, 32: RUN cycle limit; 0 disables the limit.
REQ-010 SHALL have port beat, input, 1: both comparator streams valid this cycle.
REQ-011 SHALL have port cmp_err_count, input, 32: live comparator error count, lagging by 1 cycle.
REQ-012 SHALL have port cmp_reset, output, 1: comparator counter clear.
REQ-013 SHALL have port cmp_latch, output, 1: comparator result latch pulse.
REQ-014 SHALL have port gate_en, output, 1: gates both TVALIDs into the comparator.
REQ-015 SHALL have ports busy, done, pass, timed_out and aborted, output, 1 each: status flags.
REQ-016 SHALL have port state, output, 3: current state encoding.
REQ-017 SHALL have port run_cycles, output, 32: cycles spent in RUN during the last run.

Function
REQ-018 SHALL implement states IDLE=0, CLEAR=1, RUN=2, DRAIN=3, LATCH=4, DONE=5.
REQ-019 SHALL go from IDLE or DONE to CLEAR on start, clearing done, pass, timed_out, aborted, run_cycles and the beat counter.
REQ-020 SHALL ignore start in CLEAR, RUN, DRAIN and LATCH.
REQ-021 SHALL drive cmp_reset=1 for exactly CLEAR_CYCLES cycles while in CLEAR, then enter RUN.
REQ-022 SHALL drive gate_en combinationally as (state==RUN) && (beat_cnt < cfg_window).
REQ-023 SHALL increment the 32-bit beat_cnt on gate_en && beat; the comparator therefore sees exactly cfg_window beats.
REQ-024 SHALL increment run_cycles every RUN cycle, saturating at 0xFFFFFFFF.
REQ-025 SHALL leave RUN for DRAIN when beat_cnt==cfg_window, when cmp_err_count > cfg_err_limit (early fail), or when cfg_timeout!=0 && run_cycles+1 == cfg_timeout (sets timed_out).
REQ-026 SHALL, with cfg_window=0, spend exactly one cycle in RUN with gate_en=0.
REQ-027 SHALL hold gate_en=0 for DRAIN_CYCLES cycles in DRAIN, then enter LATCH.
REQ-028 SHALL in LATCH drive cmp_latch=1 for one cycle and register pass = (cmp_err_count <= cfg_err_limit) && !timed_out, then enter DONE.
REQ-029 SHALL in DONE hold done=1 until the next start.
REQ-030 SHALL, on abort in any state other than IDLE, go to IDLE next cycle with gate_en, cmp_reset and cmp_latch at 0, aborted=1 and done=0.
REQ-031 SHALL give abort priority when start and abort coincide; an abort in IDLE has no effect.
REQ-032 SHALL drive busy=1 in states CLEAR through LATCH.
REQ-033 SHALL sample the cfg_* inputs live; software keeps them static while busy.

Reset
REQ-034 SHALL, on totalReset low, immediately force state=IDLE and every output and counter to 0, cmp_reset included.
REQ-035 SHALL, when reset occurs mid-run, abandon the run with no latch pulse and no status retained.

Structure
REQ-036 SHALL place the state enum and the status-flag struct in shared package stream_compare_pkg.
REQ-037 SHALL be one module with no sub-modules; the CLEAR and DRAIN counters share one down-counter.

Verification
REQ-038 SHALL test: window=100, limit=0, beat held high, equal data -> gate_en high for exactly 100 cycles, one cmp_latch pulse, done=1, pass=1, run_cycles=100.
REQ-039 SHALL test: window=100, limit=2, 5 mismatched beats injected at beats 10-14 -> early exit to DRAIN after the error count reaches 3, pass=0, timed_out=0.
REQ-040 SHALL test: window=50, timeout=20, beat never asserted -> RUN lasts 20 cycles, timed_out=1, pass=0, done=1.
REQ-041 SHALL test: abort at RUN cycle 7 with start asserted in the same cycle -> IDLE next cycle, aborted=1, no cmp_latch pulse, gate_en=0.
REQ-042 SHALL test: window=0 -> CLEAR 2 cycles, RUN 1 cycle, DRAIN 2 cycles, LATCH, pass=1; a start during DRAIN has no effect.
REQ-043 SHALL test: totalReset asserted during RUN -> all outputs 0 asynchronously, state=IDLE after release.
